// File: rtl/mis_vq_select18.sv
// 18-element vector quantizer: picks the din largest filter outputs, one per clock.
// Optional MIS_VQ_ROTATE_TIE_EN rotates the tie-break priority once per sample.
module mis_vq_select18 #(
    parameter int N  = 18,
    parameter int W  = 7,
    parameter int CW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic [CW-1:0]  din,
    input  logic [N*W-1:0] sfm_bus,
    output logic [N-1:0]   sv,
    output logic           sv_valid,
    output logic           busy,
    output logic           overrun
);

    // state | meaning
    // IDLE  | waiting for clk_en
    // SEL   | picking one unmasked maximum per cycle, rem down-counts to 0
    // DONE  | publishing mask to sv
    typedef enum logic [1:0] {IDLE, SEL, DONE} state_t;

    localparam int IW = $clog2(N);

    state_t         state, state_nxt;
    logic [W-1:0]   val [N];
    logic [N-1:0]   mask;
    logic [CW-1:0]  rem;
    logic [CW-1:0]  din_sat;
    logic           load, pick, commit, ovr_set;
    logic [IW-1:0]  best_idx;
    logic [W-1:0]   best_val;
    logic           found;
    logic [IW-1:0]  idx;

`ifdef MIS_VQ_ROTATE_TIE_EN
    logic [IW-1:0]  ptr;
    logic [IW:0]    scan;
`endif

    assign din_sat = (din > CW'(N)) ? CW'(N) : din;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clk_en) begin
            state_nxt = (din_sat != '0) ? SEL : DONE;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                SEL:     state_nxt = (rem == CW'(1)) ? DONE : SEL;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        load    = clk_en;
        pick    = (state == SEL) && !clk_en;
        commit  = (state == DONE) && !clk_en;
        ovr_set = clk_en && (state != IDLE);
    end

    // First unmasked element in priority order wins unless a later one is strictly larger.
    always_comb begin
        best_idx = '0;
        best_val = '0;
        found    = 1'b0;
        idx      = '0;
`ifdef MIS_VQ_ROTATE_TIE_EN
        scan     = '0;
`endif
        for (int j = 0; j < N; j++) begin
`ifdef MIS_VQ_ROTATE_TIE_EN
            scan = {1'b0, ptr} + (IW+1)'(j);
            if (scan >= (IW+1)'(N)) scan = scan - (IW+1)'(N);
            idx = scan[IW-1:0];
`else
            idx = IW'(j);
`endif
            if (!mask[idx] && (!found || (val[idx] > best_val))) begin
                best_idx = idx;
                best_val = val[idx];
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) val[i] <= '0;
            mask     <= '0;
            rem      <= '0;
            sv       <= '0;
            sv_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
`ifdef MIS_VQ_ROTATE_TIE_EN
            ptr      <= '0;
`endif
        end else begin
            busy     <= (state_nxt != IDLE);
            sv_valid <= commit;
            if (load) begin
                for (int i = 0; i < N; i++) val[i] <= sfm_bus[i*W +: W];
                mask <= '0;
                rem  <= din_sat;
            end else if (pick) begin
                mask[best_idx] <= 1'b1;
                rem            <= rem - CW'(1);
            end
            if (commit) begin
                sv <= mask;
`ifdef MIS_VQ_ROTATE_TIE_EN
                ptr <= (ptr == IW'(N-1)) ? '0 : ptr + IW'(1);
`endif
            end
            if (ovr_set) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mis_vq_select18.sv
// Self-checking bench for mis_vq_select18 against a rank-based selection model.
module tb_mis_vq_select18;

    logic           clk = 1'b0;
    logic           rst;
    logic           clk_en;
    logic [4:0]     din;
    logic [125:0]   sfm_bus;
    logic [17:0]    sv;
    logic           sv_valid;
    logic           busy;
    logic           overrun;

    int             n_assert = 0;
    int             n_fail   = 0;
    int             p_model  = 0;
    logic [6:0]     vals [18];

`ifdef MIS_VQ_ROTATE_TIE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    mis_vq_select18 dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .din      (din),
        .sfm_bus  (sfm_bus),
        .sv       (sv),
        .sv_valid (sv_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element i is chosen when fewer than k elements outrank it
    // (larger value, or equal value with earlier tie priority).
    function automatic logic [17:0] model_sel(input logic [6:0] v[18], input int d, input int p);
        logic [17:0] sel;
        int k, rank, pi, pj;
        k   = (d > 18) ? 18 : d;
        sel = '0;
        for (int i = 0; i < 18; i++) begin
            rank = 0;
            pi   = (i - p + 18) % 18;
            for (int j = 0; j < 18; j++) begin
                pj = (j - p + 18) % 18;
                if (j != i && (v[j] > v[i] || (v[j] == v[i] && pj < pi))) rank++;
            end
            sel[i] = (rank < k);
        end
        return sel;
    endfunction

    task automatic set_bus();
        for (int i = 0; i < 18; i++) sfm_bus[i*7 +: 7] = vals[i];
    endtask

    task automatic scramble_bus();
        for (int i = 0; i < 18; i++) sfm_bus[i*7 +: 7] = 7'($urandom_range(0, 127));
    endtask

    task automatic run_sample(input int d, input string tag);
        logic [17:0] exp, prev;
        int k, n, busy_cnt;
        bit stray;
        exp  = model_sel(vals, d, p_model);
        k    = (d > 18) ? 18 : d;
        prev = sv;
        set_bus();
        clk_en = 1'b1;
        din    = 5'(d);
        tick();
        clk_en = 1'b0;
        scramble_bus();
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        n = 0; busy_cnt = 1; stray = 1'b0;
        while (n < 40) begin
            tick();
            n++;
            if (sv_valid) break;
            if (busy) busy_cnt++;
            if (sv !== prev) stray = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'(k + 1));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(k + 1));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_sv_early"}, 32'(stray), 32'd0);
        check({tag, "_sv"}, 32'(sv), 32'(exp));
        check({tag, "_popcount"}, 32'($countones(sv)), 32'(k));
        tick();
        check({tag, "_valid_pulse"}, 32'(sv_valid), 32'd0);
        check({tag, "_sv_hold"}, 32'(sv), 32'(exp));
        if (ROT) p_model = (p_model + 1) % 18;
    endtask

    initial begin
        logic [17:0] exp, prev;
        int n;
        bit seen;

        rst = 1'b1; clk_en = 1'b0; din = '0; sfm_bus = '0;
        tick(); tick();
        rst = 1'b0;
        p_model = 0;
        check("rst_sv", 32'(sv), 32'd0);
        check("rst_valid", 32'(sv_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        repeat (3) tick();
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 18; i++) vals[i] = 7'(i);
        run_sample(3, "distinct");
        check("distinct_lit", 32'(sv), 32'h38000);

        for (int i = 0; i < 18; i++) vals[i] = '0;
        run_sample(5, "tie5");
        run_sample(0, "zero");
        run_sample(25, "sat25");
        check("sat25_lit", 32'(sv), 32'h3FFFF);
        run_sample(18, "full18");

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 18; i++)
                vals[i] = (t % 2 == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
            run_sample(int'($urandom_range(0, 31)), $sformatf("rand%0d", t));
        end

        // Overrun: second strobe four cycles into a din=10 selection.
        check("ovr_pre", 32'(overrun), 32'd0);
        prev = sv;
        for (int i = 0; i < 18; i++) vals[i] = 7'($urandom_range(0, 127));
        set_bus();
        clk_en = 1'b1; din = 5'd10;
        tick();
        clk_en = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (sv_valid) seen = 1'b1;
        end
        for (int i = 0; i < 18; i++) vals[i] = '0;
        set_bus();
        exp = model_sel(vals, 2, p_model);
        clk_en = 1'b1; din = 5'd2;
        tick();
        clk_en = 1'b0;
        scramble_bus();
        if (sv_valid) seen = 1'b1;
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_sv_kept", 32'(sv), 32'(prev));
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (sv_valid) break;
        end
        check("ovr_no_valid_first", 32'(seen), 32'd0);
        check("ovr_latency", 32'(n), 32'd3);
        check("ovr_sv", 32'(sv), 32'(exp));
        if (ROT) p_model = (p_model + 1) % 18;
        tick();
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a din=12 selection.
        for (int i = 0; i < 18; i++) vals[i] = 7'($urandom_range(0, 127));
        set_bus();
        clk_en = 1'b1; din = 5'd12;
        tick();
        clk_en = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p_model = 0;
        check("midrst_sv", 32'(sv), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(sv_valid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (sv_valid || busy) seen = 1'b1;
        end
        check("midrst_quiet", 32'(seen), 32'd0);
        for (int i = 0; i < 18; i++) vals[i] = '0;
        vals[9] = 7'd127;
        run_sample(1, "after_rst");
        check("after_rst_lit", 32'(sv), 32'h00200);

        // Repeated all-equal single-element picks expose tie-break ordering.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p_model = 0;
        for (int i = 0; i < 18; i++) vals[i] = '0;
        for (int s = 0; s < 3; s++) begin
            run_sample(1, $sformatf("tie_seq%0d", s));
            repeat (21) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
